// File: rtl/mpadd_pkg.sv
// mpadd_pkg: shared constants, sizing helpers and FSM state type for the serial multiprecision adder.
package mpadd_pkg;

    localparam int DEF_WIDTH = 514;
    localparam int DEF_LIMB  = 64;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mpadd_limb.sv
// mpadd_limb: combinational LIMB-bit add/subtract slice; b is inverted when sub is set.
module mpadd_limb #(
    parameter int LIMB = 64
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            sub,
    input  logic            cin,
    output logic [LIMB-1:0] sum,
    output logic            cout,
    output logic            zero
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b ^ {LIMB{sub}}} + {{LIMB{1'b0}}, cin};
    assign zero        = ~|sum;

endmodule

// File: rtl/mpadd_serial.sv
// mpadd_serial: limb-serial (WIDTH+1)-bit add/subtract with start/done handshake.
// Optional MPADD_ZERO_FLAG_EN adds result_zero, accumulated one limb at a time.
module mpadd_serial
    import mpadd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMB  = DEF_LIMB
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0] result,
    output logic           done,
    output logic           busy
`ifdef MPADD_ZERO_FLAG_EN
    ,
    output logic           result_zero
`endif
);

    localparam int NLIMBS = ceil_div(WIDTH + 1, LIMB);
    localparam int P      = NLIMBS * LIMB;
    localparam int CW     = cnt_w(NLIMBS);

    state_t          r_state;
    logic [P-1:0]    r_a, r_b, r_acc;
    logic            r_sub, r_carry, r_done;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH:0]  r_result;
    logic [LIMB-1:0] w_sum;
    logic            w_cout, w_limb_zero, w_last;
    logic [P-1:0]    w_next;

    mpadd_limb #(.LIMB(LIMB)) u_limb (
        .a    (r_a[LIMB-1:0]),
        .b    (r_b[LIMB-1:0]),
        .sub  (r_sub),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .zero (w_limb_zero)
    );

    // New limb enters at the top; after NLIMBS shifts limb 0 sits at bit 0.
    assign w_next = P'({w_sum, r_acc} >> LIMB);
    assign w_last = (r_cnt == CW'(NLIMBS - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_a     <= P'(in_a);
                    r_b     <= P'(in_b);
                    r_sub   <= subtract;
                    r_carry <= subtract;
                    r_cnt   <= '0;
                    r_state <= BUSY;
                end
            end else begin
                r_a     <= r_a >> LIMB;
                r_b     <= r_b >> LIMB;
                r_acc   <= w_next;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) begin
                    r_result <= w_next[WIDTH:0];
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end
            end
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = (r_state == BUSY);

`ifdef MPADD_ZERO_FLAG_EN
    // Padding bits of the top limb must not influence the flag.
    localparam logic [LIMB-1:0] LAST_MASK = {LIMB{1'b1}} >> (P - WIDTH - 1);

    logic r_zacc, r_result_zero, w_z;

    assign w_z = w_last ? ~|(w_sum & LAST_MASK) : w_limb_zero;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_zacc        <= 1'b0;
            r_result_zero <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start)
                r_zacc <= 1'b1;
        end else begin
            r_zacc <= r_zacc & w_z;
            if (w_last)
                r_result_zero <= r_zacc & w_z;
        end
    end

    assign result_zero = r_result_zero;
`else
    logic w_unused_zero;
    assign w_unused_zero = w_limb_zero;
`endif

endmodule

// File: tb/tb_mpadd_serial.sv
// tb_mpadd_serial: randomized self-checking bench for mpadd_serial at default and 128/32 sizes.
module tb_mpadd_serial;

    localparam int W  = 514;
    localparam int NL = 9;
    localparam int W2 = 128;

    logic           clk = 1'b0;
    logic           resetn, start, subtract, done, busy;
    logic [W-1:0]   in_a, in_b;
    logic [W:0]     result;
    logic           start2, sub2, done2, busy2;
    logic [W2-1:0]  a2, b2;
    logic [W2:0]    res2;
`ifdef MPADD_ZERO_FLAG_EN
    logic           result_zero, zero2;
`endif

    int n_cmp = 0, n_err = 0, n_done = 0, cyc = 0;
    logic [W:0] prev = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (done) n_done++;

    mpadd_serial u_dut (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .result(result), .done(done), .busy(busy)
`ifdef MPADD_ZERO_FLAG_EN
        , .result_zero(result_zero)
`endif
    );

    mpadd_serial #(.WIDTH(W2), .LIMB(32)) u_dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .subtract(sub2),
        .in_a(a2), .in_b(b2), .result(res2), .done(done2), .busy(busy2)
`ifdef MPADD_ZERO_FLAG_EN
        , .result_zero(zero2)
`endif
    );

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v = '0;
        repeat (17) v = {v[W-33:0], 32'($urandom)};
        return v;
    endfunction

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
        logic [W:0] exp;
        int lat, nb;
        exp = model(a, b, s);
        @(negedge clk);
        in_a = a; in_b = b; subtract = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1; nb = 0;
        chk({tag, "_hold"}, result, prev);
        while (!done && lat < 3 * NL) begin
            nb += int'(busy);
            in_a = rnd(); in_b = rnd(); subtract = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, (W+1)'(lat), (W+1)'(NL + 1));
        chk({tag, "_busycyc"}, (W+1)'(nb), (W+1)'(NL));
        chk({tag, "_res"}, result, exp);
        chk({tag, "_idle"}, (W+1)'(busy), '0);
`ifdef MPADD_ZERO_FLAG_EN
        chk({tag, "_zero"}, (W+1)'(result_zero), (W+1)'(exp == '0));
`endif
        prev = exp;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int t0, d0, lat;
        resetn = 1'b0; start = 1'b0; subtract = 1'b0; in_a = '0; in_b = '0;
        start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_done", (W+1)'(done), '0);
        chk("rst_busy", (W+1)'(busy), '0);
        resetn = 1'b1;

        run_op(W'(1), W'(1), 1'b0, "one_plus_one");
        run_op({W{1'b1}}, W'(1), 1'b0, "carry_chain");
        run_op(W'(5), W'(7), 1'b1, "sub_neg");
        run_op(W'(7), W'(5), 1'b1, "sub_pos");
        run_op({W{1'b1}}, {W{1'b1}}, 1'b0, "max_add");
        run_op('0, {W{1'b1}}, 1'b1, "zero_minus_max");

        // Start re-asserted mid-operation is ignored; start in done cycle is taken.
        @(negedge clk);
        ra = rnd(); rb = rnd();
        in_a = ra; in_b = rb; subtract = 1'b0; start = 1'b1; t0 = cyc; d0 = n_done;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        in_a = rnd(); in_b = rnd(); subtract = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!done && cyc - t0 < 3 * NL) @(negedge clk);
        chk("ign_lat", (W+1)'(cyc - t0), (W+1)'(NL + 1));
        chk("ign_res", result, model(ra, rb, 1'b0));
        ra = rnd(); rb = rnd();
        in_a = ra; in_b = rb; subtract = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!done && cyc - t0 < 6 * NL) @(negedge clk);
        chk("b2b_lat", (W+1)'(cyc - t0), (W+1)'(2 * (NL + 1)));
        chk("b2b_res", result, model(ra, rb, 1'b1));
        repeat (12) @(negedge clk);
        chk("ign_dones", (W+1)'(n_done - d0), (W+1)'(2));
        prev = model(ra, rb, 1'b1);

        // Reset in cycle 4 aborts the operation.
        in_a = rnd(); in_b = rnd(); subtract = 1'b0; start = 1'b1; t0 = cyc; d0 = n_done;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        chk("abort_result", result, '0);
        chk("abort_busy", (W+1)'(busy), '0);
        repeat (15) @(negedge clk);
        chk("abort_nodone", (W+1)'(n_done - d0), '0);
        prev = '0;

        for (int i = 0; i < 24; i++) begin
            ra = rnd();
            rb = ($urandom_range(0, 3) == 0) ? ra : rnd();
            if ($urandom_range(0, 5) == 0) rb = ~rb;
            run_op(ra, rb, 1'($urandom), $sformatf("rnd%0d", i));
        end

        // 128-bit / 32-bit limb instance: five limbs, done in cycle 6.
        @(negedge clk);
        a2 = 128'hFFFF_FFFF; b2 = 128'h1; sub2 = 1'b0; start2 = 1'b1; t0 = cyc;
        @(negedge clk); start2 = 1'b0;
        while (!done2 && cyc - t0 < 20) @(negedge clk);
        chk("w128_lat", (W+1)'(cyc - t0), (W+1)'(6));
        chk("w128_res", (W+1)'(res2), (W+1)'(129'h1_0000_0000));
        a2 = 128'h1234; b2 = 128'h1234; sub2 = 1'b1; start2 = 1'b1; t0 = cyc;
        @(negedge clk); start2 = 1'b0;
        while (!done2 && cyc - t0 < 20) @(negedge clk);
        chk("w128_eq_lat", (W+1)'(cyc - t0), (W+1)'(6));
        chk("w128_eq_res", (W+1)'(res2), '0);
`ifdef MPADD_ZERO_FLAG_EN
        chk("w128_eq_zero", (W+1)'(zero2), (W+1)'(1));
`endif
        a2 = {$urandom, $urandom, $urandom, $urandom}; b2 = ~a2; sub2 = 1'b0; start2 = 1'b1; t0 = cyc;
        @(negedge clk); start2 = 1'b0;
        while (!done2 && cyc - t0 < 20) @(negedge clk);
        chk("w128_ones", (W+1)'(res2), (W+1)'({1'b0, {W2{1'b1}}}));
`ifdef MPADD_ZERO_FLAG_EN
        chk("w128_ones_zero", (W+1)'(zero2), '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
